// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcodes, cycle defaults, FSM states and result type for the MD unit
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY = 2'd1;
  localparam logic [1:0] ST_DIV_BUSY = 2'd2;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // mult/multu/div/divu: the opcodes that occupy the unit
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // any opcode that touches HI/LO, used for the D-stage hazard check
  function automatic logic is_md_op(input logic [3:0] op);
    return (op != MD_NONE) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - pipeline-to-MD-unit signal bundle with master/slave views
interface md_ctrl_if;

  logic [3:0]  md_op_E;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic [3:0]  md_op_D;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output md_op_E, rs_data_E, rt_data_E, md_op_D,
    input  start, busy, stall_md, hi, lo, md_out
  );

  modport slave (
    input  md_op_E, rs_data_E, rt_data_E, md_op_D,
    output start, busy, stall_md, hi, lo, md_out
  );

endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational signed/unsigned product, quotient and remainder
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_result_t  res,
  output logic        div_zero
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic [31:0]        b_s;
  logic [31:0]        b_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Zero divisors and INT_MIN/-1 are steered to a divide-by-one: for the
  // overflow case that yields exactly q=0x80000000, r=0, and for zero the
  // result is discarded by the controller anyway.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign b_s      = (div_zero || div_ovf) ? 32'd1 : b;
  assign b_u      = div_zero ? 32'd1 : b;

  assign q_s = $signed(a) / $signed(b_s);
  assign r_s = $signed(a) % $signed(b_s);
  assign q_u = a / b_u;
  assign r_u = a % b_u;

  // pick the result matching the opcode; non-arith opcodes give zero
  always_comb begin
    res = '0;
    case (op)
      MD_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0]};
      MD_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0]};
      MD_DIV:   res = '{hi: r_s, lo: q_s};
      MD_DIVU:  res = '{hi: r_u, lo: q_u};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide unit: busy FSM, cycle counter and HI/LO registers
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic       clk,
  input logic       reset,
  md_ctrl_if.slave  bus
);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  md_result_t  pend;
  logic        pend_wr;

  md_result_t  arith_res;
  logic        div_zero;
  logic        idle;
  logic        is_mul;

  md_arith u_arith (
    .op       (bus.md_op_E),
    .a        (bus.rs_data_E),
    .b        (bus.rt_data_E),
    .res      (arith_res),
    .div_zero (div_zero)
  );

  assign idle   = (state == ST_IDLE);
  assign is_mul = (bus.md_op_E == MD_MULT) || (bus.md_op_E == MD_MULTU);

  assign bus.start    = idle && is_arith_op(bus.md_op_E);
  assign bus.busy     = !idle;
  assign bus.stall_md = (bus.start || bus.busy) && is_md_op(bus.md_op_D);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.md_out   = (bus.md_op_E == MD_MFHI) ? hi_q :
                        (bus.md_op_E == MD_MFLO) ? lo_q : 32'd0;

  // Results are captured at the start edge so later operand changes cannot
  // leak in; HI/LO only change when the countdown expires or on mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pend    <= arith_res;
            pend_wr <= is_mul || !div_zero;
            cnt     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            state   <= is_mul ? ST_MUL_BUSY : ST_DIV_BUSY;
          end else if (bus.md_op_E == MD_MTHI) begin
            hi_q <= bus.rs_data_E;
          end else if (bus.md_op_E == MD_MTLO) begin
            lo_q <= bus.rs_data_E;
          end
        end
        ST_MUL_BUSY, ST_DIV_BUSY: begin
          if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= ST_IDLE;
            if (pend_wr) begin
              hi_q <= pend.hi;
              lo_q <= pend.lo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - directed self-checking bench for md_ctrl
module tb_md_ctrl;
  import md_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  md_ctrl_if bus ();

  md_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.md_op_E   = op;
    bus.rs_data_E = rs;
    bus.rt_data_E = rt;
    #1;
  endtask

  // issue one arith op, scramble operands after the start edge, count busy cycles
  task automatic run_arith(input string tag, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int exp_busy,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    drive(op, rs, rt);
    check({tag, "_start"}, bus.start, 1);
    step();
    drive(MD_NONE, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    check({tag, "_start_off"}, bus.start, 0);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    int n;
    int s;
    bus.md_op_E   = MD_NONE;
    bus.md_op_D   = MD_NONE;
    bus.rs_data_E = 32'd0;
    bus.rt_data_E = 32'd0;
    #12;

    // reset state and combinational outputs while held in reset
    check("rst_busy", bus.busy, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_start", bus.start, 0);
    check("rst_md_out", bus.md_out, 0);
    bus.md_op_D = MD_MFLO;
    drive(MD_MULT, 32'd3, 32'd3);
    check("rst_start_comb", bus.start, 1);
    check("rst_stall_comb", bus.stall_md, 1);
    bus.md_op_D = MD_NONE;
    drive(MD_NONE, 32'd0, 32'd0);
    check("rst_stall_off", bus.stall_md, 0);
    reset = 1'b1;
    step();

    run_arith("mult",  MD_MULT,  32'hFFFF_FFFF, 32'd2, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_arith("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_arith("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu0", MD_DIVU,  32'd7,         32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_arith("divu",  MD_DIVU,  32'd100,       32'd7, 10, 32'h0000_0002, 32'h0000_000E);
    run_arith("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    // reserved opcode: no effect
    drive(4'd9, 32'h1234, 32'h1);
    check("op9_start", bus.start, 0);
    step();
    check("op9_busy", bus.busy, 0);
    check("op9_hi", bus.hi, 32'h0000_0000);
    check("op9_lo", bus.lo, 32'h8000_0000);
    check("op9_md_out", bus.md_out, 0);

    // mthi/mtlo then read back through md_out
    drive(MD_MTHI, 32'h1234_5678, 32'd0);
    check("mthi_start", bus.start, 0);
    step();
    check("mthi_busy", bus.busy, 0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    drive(MD_MFHI, 32'd0, 32'd0);
    check("mfhi_md_out", bus.md_out, 32'h1234_5678);
    drive(MD_MTLO, 32'hCAFE_F00D, 32'd0);
    step();
    drive(MD_MFLO, 32'd0, 32'd0);
    check("mflo_md_out", bus.md_out, 32'hCAFE_F00D);
    check("mflo_hi_kept", bus.hi, 32'h1234_5678);

    // opcodes arriving while busy must be ignored
    $display("note: injecting opcodes while busy (protocol violation)");
    drive(MD_MULT, 32'd3, 32'd4);
    step();
    drive(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("busy_mthi_start", bus.start, 0);
    step();
    check("busy_mthi_hi", bus.hi, 32'h1234_5678);
    drive(MD_DIV, 32'd100, 32'd3);
    check("busy_div_start", bus.start, 0);
    step();
    drive(MD_NONE, 32'd0, 32'd0);
    n = 2;
    while (bus.busy && n < 40) begin
      n++;
      step();
    end
    check("busy_ign_cycles", n, 5);
    check("busy_ign_hi", bus.hi, 32'd0);
    check("busy_ign_lo", bus.lo, 32'd12);

    // mult in E with mflo in D: stall on start cycle plus 5 busy cycles
    bus.md_op_D = MD_MFLO;
    drive(MD_MULT, 32'h0001_2345, 32'h0000_0100);
    check("stall_start", bus.stall_md, 1);
    step();
    drive(MD_NONE, 32'd0, 32'd0);
    n = 0;
    s = 0;
    while (bus.busy && n < 40) begin
      if (bus.stall_md) s++;
      n++;
      step();
    end
    check("stall_busy_cycles", s, 5);
    check("stall_after", bus.stall_md, 0);
    bus.md_op_D = MD_NONE;
    drive(MD_MFLO, 32'd0, 32'd0);
    check("stall_mflo_out", bus.md_out, 32'h0123_4500);

    // reset during a divide discards the pending result
    drive(MD_MTHI, 32'h1111_1111, 32'd0);
    step();
    drive(MD_DIV, 32'd50, 32'd5);
    step();
    drive(MD_NONE, 32'd0, 32'd0);
    step();
    step();
    step();
    check("rstmid_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_hi", bus.hi, 0);
    check("rstmid_lo", bus.lo, 0);
    step();
    reset = 1'b1;
    drive(MD_MFLO, 32'd0, 32'd0);
    check("rstmid_mflo", bus.md_out, 0);
    drive(MD_NONE, 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) step();
    check("rstmid_late_hi", bus.hi, 0);
    check("rstmid_late_lo", bus.lo, 0);
    check("rstmid_late_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy duration of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port md_op_E  input  4  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as 0.
REQ-006 SHALL have port rs_data_E  input  32  forwarded rs operand of the E-stage instruction.
REQ-007 SHALL have port rt_data_E  input  32  forwarded rt operand of the E-stage instruction.
REQ-008 SHALL have port md_op_D  input  4  D-stage MD opcode, same encoding, used for stall.
REQ-009 SHALL have port start  output  1  high while md_op_E is 1-4 and unit is idle.
REQ-010 SHALL have port busy  output  1  high while an operation is in flight.
REQ-011 SHALL have port stall_md  output  1  stall request to D stage.
REQ-012 SHALL have port hi  output  32  architectural HI register.
REQ-013 SHALL have port lo  output  32  architectural LO register.
REQ-014 SHALL have port md_out  output  32  mfhi/mflo read data for the E-stage result mux.

Function
REQ-015 SHALL implement states IDLE, MUL_BUSY, DIV_BUSY with a 4-bit down-counter cnt.
REQ-016 IDLE with md_op_E in 1-2: start=1 combinationally; at the edge, latch {prod_hi,prod_lo}, cnt=MULT_CYCLES, go MUL_BUSY.
REQ-017 IDLE with md_op_E in 3-4: start=1; at the edge, latch quotient/remainder, cnt=DIV_CYCLES, go DIV_BUSY.
REQ-018 busy SHALL equal (state != IDLE); with defaults busy is high exactly 5 (mult) or 10 (div) cycles after the start edge.
REQ-019 In MUL_BUSY/DIV_BUSY, cnt SHALL decrement each edge; on the edge where cnt goes 1->0, hi/lo SHALL take the pending result and state SHALL return to IDLE.
REQ-020 mult: signed 32x32->64, hi=product[63:32], lo=product[31:0]; multu: same, unsigned.
REQ-021 div: signed, lo=quotient truncated toward zero, hi=remainder with sign of dividend; divu: unsigned.
REQ-022 div/divu with rt_data_E==0 SHALL still run DIV_CYCLES and assert busy, but SHALL leave hi and lo unchanged at completion.
REQ-023 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 mthi/mtlo in IDLE SHALL write rs_data_E into hi/lo at the next edge; they do not assert start or busy.
REQ-025 md_out SHALL be hi for md_op_E==5, lo for 6, else 0; purely combinational, no added latency.
REQ-026 stall_md SHALL be (start | busy) & (md_op_D in 1-8).
REQ-027 Any md_op_E in 1-8 arriving while busy SHALL be ignored (no state change); the bench flags it as a protocol error.
REQ-028 Operands SHALL be sampled only at the start edge; later changes on rs_data_E/rt_data_E SHALL NOT affect the pending result.
REQ-029 Opcodes 0 and 9-15 SHALL cause no state change.

Reset
REQ-030 While reset is low: state=IDLE, cnt=0, hi=0, lo=0, pending result=0, busy=0, asynchronously.
REQ-031 Reset mid-operation SHALL discard the pending result; hi/lo read 0 after release.
REQ-032 start, stall_md, and md_out SHALL follow their combinational definitions during reset (busy=0, hi=lo=0).

Structure
REQ-033 md_op encodings, MULT_CYCLES/DIV_CYCLES defaults, and the state enum SHALL live in shared package md_pkg.
REQ-034 Signed/unsigned product, quotient, and remainder SHALL be computed in one combinational sub-module md_arith; md_ctrl holds the FSM, counter, and registers.
REQ-035 Implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-036 mult rs=0xFFFFFFFF, rt=2 -> start 1 cycle, busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-037 div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
REQ-038 mult in E with mflo in D -> stall_md=1 on the start cycle and the following 5 busy cycles, 0 after; mflo then sees md_out=new lo.
REQ-039 mthi rs=0x12345678, then mfhi -> hi=0x12345678 one edge later, md_out=0x12345678, no busy.
REQ-040 div started, reset asserted low at busy cycle 4 -> busy=0, hi=lo=0 immediately; after release, mflo reads 0.
